ucode_sequencer: RTL and testbench
==================================

# ucode_sequencer

Parametrised microcoded control sequencer for the 6502 core; it replaces the fixed-width hard-wired control state machine with a writable control store. Each cycle it reads the microword for the current state, drives its control field onto `controls`, and selects the next state from the microword's mode field: sequential, jump, flag-conditional branch, or opcode dispatch. It sits between the instruction/data bus and the datapath. The datapath processor status register feeds the conditional branches.

## Interface
Parameters:
- `CTRL_W`, 37: width of the control field driven to the datapath.
- `STATE_W`, 9: state register width; store depth is 2^STATE_W.
- `RESET_STATE`, 9'h100: state loaded on reset.
- `IRQ_STATE`, 9'h1F0: interrupt entry state (used only with UCODE_IRQ_EN).
- Derived `MW = CTRL_W + STATE_W + 6`. This is the microword width and is not overridable.

Ports:
- `ph1`  in  1  single clock; all state updates on rising edge.
- `resetb`  in  1  synchronous, active-low reset.
- `data_in`  in  8  opcode byte, sampled in dispatch states.
- `p`  in  8  processor status flags (C,Z,I,D,B,-,V,N at bits 0..7).
- `stall`  in  1  hold current state; suppress controls.
- `irq`  in  1  interrupt request, level-sensitive.
- `wr_en`  in  1  control-store write strobe.
- `wr_addr`  in  STATE_W  control-store write address.
- `wr_data`  in  MW  microword to write.
- `controls`  out  CTRL_W  control field of the current microword.
- `state`  out  STATE_W  current state.
- `sync`  out  1  high while the current microword is in dispatch mode (opcode fetch).

## Operation
- Microword layout, LSB first:
  - `[CTRL_W-1:0]` controls.
  - next (STATE_W bits).
  - mode (2 bits).
  - csel (3 bits).
  - pol (1 bit).
- Read is combinational from `store[state]`. Write is synchronous: on a `ph1` edge with `wr_en` high, `store[wr_addr] <= wr_data`. Writes are honoured regardless of `resetb` and `stall`.
- Next-state selection by mode:
  - 00 SEQ: `state + 1`, modulo 2^STATE_W. From all-ones it wraps to 0.
  - 01 JUMP: `next`.
  - 10 COND: if `p[csel] == pol`, go to `next`; otherwise go to `state + 1`.
  - 11 DISPATCH: `{0, data_in}`. Opcode entry points occupy states 0x000–0x0FF.
- Stall: while `stall` = 1, `state` holds and `controls` = 0. `sync` still reflects the mode. When `stall` releases, the held state executes normally.
- Reset: while `resetb` = 0 at an edge, `state <= RESET_STATE`. While `resetb` is low, `controls` = 0 and `sync` = 0.
  - Reset has priority over stall, irq and next-state logic.
  - A reset mid-instruction abandons that instruction.
  - The store contents are not reset.
- Simultaneous write to the address of the current state: this cycle's transition uses the old word. The new word is visible next cycle.
- `controls` is not registered. Downstream logic samples it on the next `ph1` edge.

## Timing
- State transition latency: 1 cycle.
- Control-store write to read-back: 1 cycle.
- `data_in` is sampled at the edge ending a DISPATCH cycle. The opcode must be stable at that edge, and the entry microword executes in the following cycle.
- First cycle after `resetb` rises: `state` = RESET_STATE, and `controls` = `store[RESET_STATE]` control field.

## Configuration
- `UCODE_IRQ_EN` defined:
  - In a DISPATCH cycle with `irq` = 1 and `p[2]` = 0, next state is IRQ_STATE instead of the opcode entry.
  - `data_in` is ignored for that dispatch.
  - Stall still takes precedence: no transition occurs while stalled.
- `UCODE_IRQ_EN` not defined: the `irq` port is present but ignored. DISPATCH always goes to the opcode entry.

## Test plan
- Reset with default parameters:
  - Stimulus: hold `resetb` = 0 for 3 cycles, then release.
  - Response: `state` = 0x100 during and immediately after reset; `controls` = 0 while reset is low.
- Sequential wrap:
  - Stimulus: write SEQ words at 0x1FF and 0x000; jump to 0x1FF.
  - Response: next states are 0x000, then 0x001.
- Conditional branch:
  - Stimulus: word at 0x120 is COND with csel = 1, pol = 1, next = 0x150.
  - Response: with `p` = 0x02 the next state is 0x150; with `p` = 0x00 it is 0x121.
- Dispatch:
  - Stimulus: `data_in` = 0xA9 in a DISPATCH state.
  - Response: `sync` = 1 in that cycle; next state = 0x0A9.
- Stall:
  - Stimulus: assert `stall` for 4 cycles in state 0x121.
  - Response: `state` holds at 0x121 and `controls` = 0 throughout; state advances on the first unstalled edge.
- Interrupt entry (UCODE_IRQ_EN builds only):
  - Stimulus: `irq` = 1 with `p` = 0x00 at dispatch.
  - Response: next state = 0x1F0.
  - Stimulus: same, with `p` = 0x04.
  - Response: next state = opcode entry.
- Write-through:
  - Stimulus: rewrite the current state's word while executing it.
  - Response: `controls` changes on the following cycle, not the current one.

Source files
------------

// File: rtl/ucode_sequencer.sv
// ucode_sequencer
//   Microcoded control sequencer for the 6502 core. A writable control store
//   holds one microword per state. Each cycle the word addressed by the current
//   state drives its control field onto `controls`, and its mode field picks the
//   next state: sequential, jump, flag-conditional branch or opcode dispatch.
//
//   Microword layout (LSB first):
//     [CTRL_W-1:0]  controls
//     next          STATE_W bits, branch/jump target
//     mode          2 bits (00 SEQ, 01 JUMP, 10 COND, 11 DISPATCH)
//     csel          3 bits, index of the status flag tested by COND
//     pol           1 bit, flag value that makes COND take the branch
//
//   Optional feature macro: UCODE_IRQ_EN
//     When defined, a DISPATCH cycle with irq=1 and the I flag (p[2]) clear
//     enters IRQ_STATE instead of the opcode entry point. When undefined the
//     irq port is present but ignored.
//
// Ports:
//   ph1       in   clock, all state updates on the rising edge
//   resetb    in   synchronous active-low reset
//   data_in   in   opcode byte, sampled at the end of a DISPATCH cycle
//   p         in   processor status flags (C,Z,I,D,B,-,V,N at bits 0..7)
//   stall     in   hold current state, force controls to zero
//   irq       in   level-sensitive interrupt request
//   wr_en     in   control-store write strobe
//   wr_addr   in   control-store write address
//   wr_data   in   microword to write
//   controls  out  control field of the current microword (combinational)
//   state     out  current state
//   sync      out  high while the current microword is in DISPATCH mode

module ucode_sequencer #(
  parameter int                 CTRL_W      = 37,
  parameter int                 STATE_W     = 9,
  parameter logic [STATE_W-1:0] RESET_STATE = 9'h100,
  parameter logic [STATE_W-1:0] IRQ_STATE   = 9'h1F0,
  localparam int                MW          = CTRL_W + STATE_W + 6
) (
  input  logic               ph1,
  input  logic               resetb,
  input  logic [7:0]         data_in,
  input  logic [7:0]         p,
  input  logic               stall,
  input  logic               irq,
  input  logic               wr_en,
  input  logic [STATE_W-1:0] wr_addr,
  input  logic [MW-1:0]      wr_data,
  output logic [CTRL_W-1:0]  controls,
  output logic [STATE_W-1:0] state,
  output logic               sync
);

  localparam logic [1:0] MODE_SEQ      = 2'b00;
  localparam logic [1:0] MODE_JUMP     = 2'b01;
  localparam logic [1:0] MODE_COND     = 2'b10;
  localparam logic [1:0] MODE_DISPATCH = 2'b11;

  // Interrupt-disable flag position in the status register.
  localparam int P_I_BIT = 2;

  localparam int DEPTH = 1 << STATE_W;

  logic [MW-1:0]      store_q [0:DEPTH-1];
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  logic [MW-1:0]      word;
  logic [CTRL_W-1:0]  word_ctrl;
  logic [STATE_W-1:0] word_next;
  logic [1:0]         word_mode;
  logic [2:0]         word_csel;
  logic               word_pol;
  logic [STATE_W-1:0] state_inc;

  // Combinational read of the current microword. A write to the same address
  // lands at the edge, so the transition taken at that edge still uses the
  // old word and the new one is seen from the next cycle on.
  assign word      = store_q[state_q];
  assign word_ctrl = word[CTRL_W-1:0];
  assign word_next = word[CTRL_W +: STATE_W];
  assign word_mode = word[CTRL_W+STATE_W +: 2];
  assign word_csel = word[CTRL_W+STATE_W+2 +: 3];
  assign word_pol  = word[MW-1];

  // Natural modulo-2^STATE_W increment: all-ones wraps to zero.
  assign state_inc = state_q + STATE_W'(1);

`ifndef UCODE_IRQ_EN
  logic irq_unused;
  assign irq_unused = irq;
`endif

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (word_mode)
        MODE_SEQ:  state_d = state_inc;
        MODE_JUMP: state_d = word_next;
        MODE_COND: state_d = (p[word_csel] == word_pol) ? word_next : state_inc;
        default: begin
          // Opcode entry points live in the bottom 256 states.
          state_d = STATE_W'(data_in);
`ifdef UCODE_IRQ_EN
          if (irq && !p[P_I_BIT]) begin
            state_d = IRQ_STATE;
          end
`endif
        end
      endcase
    end
  end

  // Reset only touches the state register; the store is left intact so a
  // reset never requires the microcode to be reloaded.
  always_ff @(posedge ph1) begin
    if (!resetb) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge ph1) begin
    if (wr_en) begin
      store_q[wr_addr] <= wr_data;
    end
  end

  assign state    = state_q;
  assign controls = (!resetb || stall) ? '0 : word_ctrl;
  assign sync     = resetb && (word_mode == MODE_DISPATCH);

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: loads a small microprogram under reset, walks it
// with a table of vectors, then covers write-through and mid-instruction reset
// with hand-written sequences. Expected next states go through a queue.

module tb_ucode_sequencer;

  localparam int CTRL_W  = 37;
  localparam int STATE_W = 9;
  localparam int MW      = CTRL_W + STATE_W + 6;

  localparam logic [1:0] M_SEQ  = 2'd0;
  localparam logic [1:0] M_JMP  = 2'd1;
  localparam logic [1:0] M_COND = 2'd2;
  localparam logic [1:0] M_DISP = 2'd3;

`ifdef UCODE_IRQ_EN
  localparam logic [8:0] IRQ_TGT = 9'h1F0;
`else
  localparam logic [8:0] IRQ_TGT = 9'h055;
`endif

  logic              ph1 = 1'b0;
  logic              resetb;
  logic [7:0]        data_in;
  logic [7:0]        p;
  logic              stall;
  logic              irq;
  logic              wr_en;
  logic [8:0]        wr_addr;
  logic [MW-1:0]     wr_data;
  logic [CTRL_W-1:0] controls;
  logic [8:0]        state;
  logic              sync;

  always #5 ph1 = ~ph1;

  ucode_sequencer dut (
    .ph1      (ph1),
    .resetb   (resetb),
    .data_in  (data_in),
    .p        (p),
    .stall    (stall),
    .irq      (irq),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .controls (controls),
    .state    (state),
    .sync     (sync)
  );

  typedef struct {
    logic              stall;
    logic [7:0]        p;
    logic [7:0]        din;
    logic              irq;
    logic [8:0]        st;
    logic [CTRL_W-1:0] ctrl;
    logic              sync;
    logic [8:0]        nxt;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  vec_t       tbl[$];

  localparam logic [CTRL_W-1:0] NEWC = 37'h1F_0F0F_0F0F;

  function automatic logic [CTRL_W-1:0] ctrl_of(input logic [8:0] a);
    return {a, 28'h1234567} ^ {28'h0, a};
  endfunction

  function automatic logic [MW-1:0] mw(input logic [CTRL_W-1:0] c, input logic [8:0] nxt,
                                       input logic [1:0] mode, input logic [2:0] csel,
                                       input logic pol);
    return {pol, csel, mode, nxt, c};
  endfunction

  function automatic vec_t mk(input logic st_in, input logic [7:0] pv, input logic [7:0] din,
                              input logic irqv, input logic [8:0] st, input logic syncv,
                              input logic [8:0] nxt);
    vec_t v;
    v.stall = st_in;
    v.p     = pv;
    v.din   = din;
    v.irq   = irqv;
    v.st    = st;
    v.ctrl  = st_in ? '0 : ctrl_of(st);
    v.sync  = syncv;
    v.nxt   = nxt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_next(input string name);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, state %h", name, state);
    end else begin
      check(name, 64'(state), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [MW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge ph1);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic apply(input string tag, input vec_t v);
    stall   = v.stall;
    p       = v.p;
    data_in = v.din;
    irq     = v.irq;
    #1;
    check({tag, "_state"}, 64'(state), 64'(v.st));
    check({tag, "_ctrl"}, 64'(controls), 64'(v.ctrl));
    check({tag, "_sync"}, 64'(sync), 64'(v.sync));
    exp_q.push_back(v.nxt);
    @(posedge ph1);
    #1;
    check_next({tag, "_next"});
  endtask

  initial begin
    resetb  = 1'b0;
    stall   = 1'b0;
    irq     = 1'b0;
    wr_en   = 1'b0;
    data_in = 8'h00;
    p       = 8'h00;
    wr_addr = '0;
    wr_data = '0;

    repeat (3) @(posedge ph1);
    #1;
    check("rst3_state", 64'(state), 64'h100);
    check("rst3_ctrl", 64'(controls), 64'h0);
    check("rst3_sync", 64'(sync), 64'h0);

    // Load the store while reset is held: every word defaults to SEQ.
    for (int a = 0; a < 512; a++) begin
      wr(9'(a), mw(ctrl_of(9'(a)), 9'h000, M_SEQ, 3'd0, 1'b0));
    end
    wr(9'h100, mw(ctrl_of(9'h100), 9'h1FF, M_JMP,  3'd0, 1'b0));
    wr(9'h001, mw(ctrl_of(9'h001), 9'h120, M_JMP,  3'd0, 1'b0));
    wr(9'h120, mw(ctrl_of(9'h120), 9'h150, M_COND, 3'd1, 1'b1));
    wr(9'h150, mw(ctrl_of(9'h150), 9'h120, M_JMP,  3'd0, 1'b0));
    wr(9'h122, mw(ctrl_of(9'h122), 9'h000, M_DISP, 3'd0, 1'b0));
    wr(9'h0A9, mw(ctrl_of(9'h0A9), 9'h120, M_JMP,  3'd0, 1'b0));
    wr(9'h03D, mw(ctrl_of(9'h03D), 9'h122, M_JMP,  3'd0, 1'b0));
    wr(9'h1F0, mw(ctrl_of(9'h1F0), 9'h170, M_JMP,  3'd0, 1'b0));
    wr(9'h055, mw(ctrl_of(9'h055), 9'h170, M_JMP,  3'd0, 1'b0));
    wr(9'h170, mw(ctrl_of(9'h170), 9'h170, M_JMP,  3'd0, 1'b0));

    check("rst_state", 64'(state), 64'h100);
    check("rst_ctrl", 64'(controls), 64'h0);
    check("rst_sync", 64'(sync), 64'h0);

    //             stall p      din    irq  state   sync next
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h100, 0, 9'h1FF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h1FF, 0, 9'h000));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h000, 0, 9'h001));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h001, 0, 9'h120));
    tbl.push_back(mk(0, 8'h02, 8'h00, 0, 9'h120, 0, 9'h150));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h150, 0, 9'h120));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h120, 0, 9'h121));
    tbl.push_back(mk(1, 8'h00, 8'h00, 0, 9'h121, 0, 9'h121));
    tbl.push_back(mk(1, 8'h00, 8'h00, 0, 9'h121, 0, 9'h121));
    tbl.push_back(mk(1, 8'h00, 8'h00, 0, 9'h121, 0, 9'h121));
    tbl.push_back(mk(1, 8'h00, 8'h00, 0, 9'h121, 0, 9'h121));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h121, 0, 9'h122));
    tbl.push_back(mk(1, 8'h00, 8'hA9, 0, 9'h122, 1, 9'h122));
    tbl.push_back(mk(0, 8'h00, 8'hA9, 0, 9'h122, 1, 9'h0A9));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h0A9, 0, 9'h120));
    tbl.push_back(mk(0, 8'hFD, 8'h00, 0, 9'h120, 0, 9'h121));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h121, 0, 9'h122));
    tbl.push_back(mk(0, 8'h04, 8'h3C, 1, 9'h122, 1, 9'h03C));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h03C, 0, 9'h03D));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h03D, 0, 9'h122));
    tbl.push_back(mk(0, 8'h00, 8'h55, 1, 9'h122, 1, IRQ_TGT));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, IRQ_TGT, 0, 9'h170));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 9'h170, 0, 9'h170));

    resetb = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Rewrite the word being executed: old word governs this edge.
    wr_en   = 1'b1;
    wr_addr = 9'h170;
    wr_data = mw(NEWC, 9'h100, M_JMP, 3'd0, 1'b0);
    #1;
    check("wt_old_ctrl", 64'(controls), 64'(ctrl_of(9'h170)));
    exp_q.push_back(9'h170);
    @(posedge ph1);
    #1;
    wr_en = 1'b0;
    check_next("wt_old_next");
    check("wt_new_ctrl", 64'(controls), 64'(NEWC));
    exp_q.push_back(9'h100);
    @(posedge ph1);
    #1;
    check_next("wt_new_next");

    // Walk to the dispatch state, then reset in the middle of it.
    apply("rs0", mk(0, 8'h00, 8'h00, 0, 9'h100, 0, 9'h1FF));
    apply("rs1", mk(0, 8'h00, 8'h00, 0, 9'h1FF, 0, 9'h000));
    apply("rs2", mk(0, 8'h00, 8'h00, 0, 9'h000, 0, 9'h001));
    apply("rs3", mk(0, 8'h00, 8'h00, 0, 9'h001, 0, 9'h120));
    apply("rs4", mk(0, 8'h00, 8'h00, 0, 9'h120, 0, 9'h121));
    apply("rs5", mk(0, 8'h00, 8'h00, 0, 9'h121, 0, 9'h122));
    resetb  = 1'b0;
    stall   = 1'b1;
    irq     = 1'b1;
    data_in = 8'hA9;
    #1;
    check("mid_rst_ctrl", 64'(controls), 64'h0);
    check("mid_rst_sync", 64'(sync), 64'h0);
    exp_q.push_back(9'h100);
    @(posedge ph1);
    #1;
    check_next("mid_rst_next");
    check("mid_rst_ctrl2", 64'(controls), 64'h0);
    resetb = 1'b1;
    stall  = 1'b0;
    irq    = 1'b0;
    #1;
    check("post_rst_state", 64'(state), 64'h100);
    check("post_rst_ctrl", 64'(controls), 64'(ctrl_of(9'h100)));
    exp_q.push_back(9'h1FF);
    @(posedge ph1);
    #1;
    check_next("store_kept_next");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
